gf163_mult_io: RTL and testbench



---
 rtl/gf163_mult_io.sv | 151 +++++++++++++++
 tb/tb_gf163_mult_io.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_mult_io.sv
// gf163_mult_io: bus-side operand/result stage for the GF(2^163) multiplier.
// Collects A and B as 32-bit words, holds mul_start for the whole operation,
// captures the product on mul_done and serves it back word by word.
// A cycle watchdog returns the bus side to IDLE if the multiplier never answers.
`timescale 1ns/1ps
module gf163_mult_io #(
    parameter int WORD_W  = 32,
    parameter int NWORDS  = 6,
    parameter int TIMEOUT = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [2:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              go,
    input  logic [2:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic              busy,
    output logic              res_valid,
    output logic              timeout,
    output logic [162:0]      mul_a,
    output logic [162:0]      mul_b,
    output logic              mul_start,
    input  logic [162:0]      mul_z,
    input  logic              mul_done
);

    localparam int          N        = 163;
    // Width of the topmost, partial operand word (bits [162:160]).
    localparam int          LAST_W   = N - (NWORDS - 1) * WORD_W;
    localparam logic [8:0]  CNT_LAST = 9'(TIMEOUT - 1);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [N-1:0]      a_reg, a_next;
    logic [N-1:0]      b_reg, b_next;
    logic [N-1:0]      res_reg, res_next;
    logic [8:0]        cnt_reg, cnt_next;
    logic              res_valid_reg, res_valid_next;
    logic              timeout_reg, timeout_next;

    logic              wr_ok;
    logic [NWORDS-1:0] wr_a_hit;
    logic [NWORDS-1:0] wr_b_hit;
    logic [WORD_W-1:0] res_word [8];

    // Operand words only change while IDLE, so the multiplier sees stable inputs in RUN.
    assign wr_ok = wr_en && (state_reg == ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_op
            assign wr_a_hit[gi] = wr_ok && !wr_sel && (wr_idx == 3'(gi));
            assign wr_b_hit[gi] = wr_ok &&  wr_sel && (wr_idx == 3'(gi));
            if (gi < NWORDS - 1) begin : g_full
                assign a_next[gi*WORD_W +: WORD_W] = wr_a_hit[gi] ? wr_data : a_reg[gi*WORD_W +: WORD_W];
                assign b_next[gi*WORD_W +: WORD_W] = wr_b_hit[gi] ? wr_data : b_reg[gi*WORD_W +: WORD_W];
            end else begin : g_last
                // Only the low bits of the last word land in the operand; the rest are dropped.
                assign a_next[N-1 -: LAST_W] = wr_a_hit[gi] ? wr_data[LAST_W-1:0] : a_reg[N-1 -: LAST_W];
                assign b_next[N-1 -: LAST_W] = wr_b_hit[gi] ? wr_data[LAST_W-1:0] : b_reg[N-1 -: LAST_W];
            end
        end

        // Result word view: word NWORDS-1 is zero-extended, indices past it read 0.
        for (gi = 0; gi < 8; gi++) begin : g_rd
            if (gi < NWORDS - 1) begin : g_full
                assign res_word[gi] = res_reg[gi*WORD_W +: WORD_W];
            end else if (gi == NWORDS - 1) begin : g_last
                assign res_word[gi] = {{(WORD_W-LAST_W){1'b0}}, res_reg[N-1 -: LAST_W]};
            end else begin : g_none
                assign res_word[gi] = '0;
            end
        end
    endgenerate

    // Control: launch, completion capture and watchdog abort.
    always_comb begin
        state_next     = state_reg;
        res_next       = res_reg;
        cnt_next       = cnt_reg;
        res_valid_next = res_valid_reg;
        timeout_next   = timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                // A spurious mul_done here is deliberately ignored.
                if (wr_en) begin
                    res_valid_next = 1'b0;
                end
                if (go) begin
                    state_next     = ST_RUN;
                    res_next       = '0;
                    res_valid_next = 1'b0;
                    timeout_next   = 1'b0;
                    cnt_next       = '0;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg + 9'd1;
                // mul_done has priority over a coinciding watchdog expiry.
                if (mul_done) begin
                    res_next       = mul_z;
                    res_valid_next = 1'b1;
                    state_next     = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next   = 1'b1;
                    res_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            res_reg       <= '0;
            cnt_reg       <= '0;
            res_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            res_reg       <= res_next;
            cnt_reg       <= cnt_next;
            res_valid_reg <= res_valid_next;
            timeout_reg   <= timeout_next;
        end
    end

    // mul_start is decoded from state so it drops as soon as rst asserts.
    assign busy      = (state_reg == ST_RUN);
    assign mul_start = (state_reg == ST_RUN);
    assign res_valid = res_valid_reg;
    assign timeout   = timeout_reg;
    assign mul_a     = a_reg;
    assign mul_b     = b_reg;
    assign rd_data   = res_word[rd_idx];

endmodule

// File: tb/tb_gf163_mult_io.sv
// tb_gf163_mult_io: scoreboard bench for gf163_mult_io with a behavioural
// multiplier stub and a polynomial-arithmetic reference for GF(2^163).
`timescale 1ns/1ps
module tb_gf163_mult_io;

    localparam int TIMEOUT = 400;
    localparam int K_DONE  = 0;
    localparam int K_TMO   = 1;
    localparam int K_RST   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en, wr_sel, go;
    logic [2:0]   wr_idx, rd_idx;
    logic [31:0]  wr_data, rd_data;
    logic         busy, res_valid, timeout, mul_start, mul_done;
    logic [162:0] mul_a, mul_b, mul_z;

    typedef struct {
        int           kind;
        logic [162:0] a;
        logic [162:0] b;
        logic [162:0] prod;
        int           dur;
    } rec_t;

    rec_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           stub_lat = -1;
    logic         spur_req = 1'b0;
    logic [162:0] sa = '0;
    logic [162:0] sb = '0;

    gf163_mult_io #(.WORD_W(32), .NWORDS(6), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
        .wr_data(wr_data), .go(go), .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .res_valid(res_valid), .timeout(timeout),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_z(mul_z), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Product in GF(2)[x] / (x^163 + x^7 + x^6 + x^3 + 1).
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] p;
        p = '0;
        for (int i = 0; i < 163; i++)
            if (b[i]) p = p ^ ({162'b0, a} << i);
        for (int i = 324; i >= 163; i--)
            if (p[i]) begin
                p[i] = 1'b0;
                p[i-163] = ~p[i-163];
                p[i-160] = ~p[i-160];
                p[i-157] = ~p[i-157];
                p[i-156] = ~p[i-156];
            end
        return p[162:0];
    endfunction

    function automatic logic [162:0] upd(input logic [162:0] v, input int idx, input logic [31:0] d);
        logic [162:0] m;
        if (idx > 5) return v;
        m = 163'hFFFF_FFFF << (32 * idx);
        return (v & ~m) | (163'(d) << (32 * idx));
    endfunction

    function automatic logic [31:0] word_of(input logic [162:0] v, input int i);
        if (i > 5) return 32'd0;
        return 32'(v >> (32 * i));
    endfunction

    function automatic logic [162:0] rand163();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Multiplier stub: answers after stub_lat cycles of held start (never if negative).
    initial begin : stub
        int cnt;
        cnt = 0;
        mul_done = 1'b0;
        mul_z = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                if (stub_lat >= 0 && cnt == stub_lat) begin
                    mul_done = 1'b1;
                    mul_z = gf_mul(mul_a, mul_b);
                end else begin
                    mul_done = 1'b0;
                    mul_z = rand163();
                end
                cnt++;
            end else begin
                cnt = 0;
                mul_done = spur_req;
                mul_z = spur_req ? rand163() : '0;
            end
        end
    end

    // Monitor: pops an expectation whenever an operation ends, otherwise sweeps result words.
    initial begin : monitor
        rec_t         r;
        logic         prev_busy;
        int           run_len;
        int           ridx;
        logic [162:0] held;
        logic [162:0] exp_w;
        held = '0; prev_busy = 1'b0; run_len = 0; ridx = 0; rd_idx = 3'd0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mul_start", mul_start, 0);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i); #0.1;
            chk($sformatf("rst_rd%0d", i), rd_data, 0);
        end
        forever begin
            @(negedge clk);
            if (busy) begin
                run_len++;
                chk("mul_start_run", mul_start, 1);
            end
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    chk("queue_depth", q.size(), 1);
                end else begin
                    r = q.pop_front();
                    if (r.dur >= 0) chk("run_len", run_len, r.dur);
                    held = (r.kind == K_DONE) ? r.prod : '0;
                    chk("end_res_valid", res_valid, (r.kind == K_DONE) ? 1 : 0);
                    chk("end_timeout", timeout, (r.kind == K_TMO) ? 1 : 0);
                    chk("end_mul_a", mul_a, r.a);
                    chk("end_mul_b", mul_b, r.b);
                    exp_w = held;
                    for (int i = 0; i < 8; i++) begin
                        rd_idx = 3'(i); #0.1;
                        chk($sformatf("end_rd%0d", i), rd_data, word_of(exp_w, i));
                    end
                end
                run_len = 0;
            end else begin
                rd_idx = 3'(ridx); #0.1;
                chk("rd_word", rd_data, busy ? 32'd0 : word_of(held, ridx));
                ridx = (ridx + 1) % 8;
            end
            prev_busy = busy;
        end
    end

    task automatic wr(input bit sel, input int idx, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_idx = 3'(idx); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) sb = upd(sb, idx, d);
        else     sa = upd(sa, idx, d);
        chk("wr_mul_a", mul_a, sa);
        chk("wr_mul_b", mul_b, sb);
        chk("wr_res_valid", res_valid, 0);
    endtask

    task automatic run_op(input int kind, input int lat, input bit co_wr,
                          input logic [31:0] co_d, input bit disturb);
        rec_t r;
        int   w;
        @(negedge clk);
        stub_lat = lat;
        if (co_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 3'd0; wr_data = co_d;
            sa = upd(sa, 0, co_d);
        end
        go = 1'b1;
        r.kind = kind;
        r.a    = (kind == K_RST) ? '0 : sa;
        r.b    = (kind == K_RST) ? '0 : sb;
        r.prod = gf_mul(sa, sb);
        r.dur  = (kind == K_TMO) ? TIMEOUT : (kind == K_DONE) ? lat + 1 : -1;
        q.push_back(r);
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        chk("launch_busy", busy, 1);
        chk("launch_mul_start", mul_start, 1);
        chk("launch_timeout", timeout, 0);
        chk("launch_res_valid", res_valid, 0);
        chk("launch_mul_a", mul_a, sa);
        chk("launch_mul_b", mul_b, sb);
        if (disturb) begin
            repeat (10) @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 3'd0; wr_data = ~sa[31:0]; go = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; go = 1'b0;
            chk("run_write_ignored", mul_a, sa);
        end
        if (kind == K_RST) begin
            repeat (48) @(negedge clk);
            @(posedge clk); #2 rst = 1'b1;
            #1;
            chk("midrst_mul_start", mul_start, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_mul_a", mul_a, 0);
            chk("midrst_mul_b", mul_b, 0);
            sa = '0; sb = '0;
            @(posedge clk); #2 rst = 1'b0;
        end
        w = 0;
        while (busy && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("run_bounded", (w < 1000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Stimulus sequence.
    initial begin : stim
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = 3'd0; wr_data = 32'd0; go = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // 1 * x = x
        wr(0, 0, 32'h1);
        wr(1, 0, 32'h2);
        run_op(K_DONE, $urandom_range(160, 170), 0, 32'd0, 0);

        // x^162 * x reduces to x^7 + x^6 + x^3 + 1
        wr(0, 0, 32'h0);
        wr(0, 5, 32'h4);
        run_op(K_DONE, $urandom_range(160, 170), 0, 32'd0, 0);

        // Top word keeps only 3 bits; a write after completion drops res_valid.
        chk("done_res_valid", res_valid, 1);
        wr(0, 5, 32'hFFFF_FFFF);
        chk("top_bits", mul_a[162:160], 3'b111);

        // Same-cycle write and go, then a disturbed run.
        run_op(K_DONE, $urandom_range(160, 170), 1, $urandom, 0);
        run_op(K_DONE, $urandom_range(160, 170), 0, 32'd0, 1);

        // Random operands, including ignored indices 6 and 7.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) begin
                wr(0, i, $urandom);
                wr(1, i, $urandom);
            end
            run_op(K_DONE, $urandom_range(150, 175), 0, 32'd0, 0);
        end

        // Spurious mul_done while IDLE must leave the result alone.
        @(posedge clk); #2 spur_req = 1'b1;
        @(posedge clk); #2 spur_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("spurious_res_valid", res_valid, 1);

        // Hung multiplier, recovery via go, then done coinciding with expiry.
        run_op(K_TMO, -1, 0, 32'd0, 0);
        run_op(K_DONE, $urandom_range(160, 170), 0, 32'd0, 0);
        run_op(K_DONE, TIMEOUT - 1, 0, 32'd0, 0);

        // Reset in the middle of a run, then a fresh product.
        run_op(K_RST, 200, 0, 32'd0, 0);
        for (int i = 0; i < 6; i++) begin
            wr(0, i, $urandom);
            wr(1, i, $urandom);
        end
        run_op(K_DONE, $urandom_range(160, 170), 0, 32'd0, 0);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
